// File: rtl/rstseq_pkg.sv
// Shared types and defaults for the reset sequencer.
// The ERROR state only exists when RSTSEQ_TIMEOUT_EN is defined.
package rstseq_pkg;

   localparam int DEF_N_STAGES       = 4;
   localparam int DEF_HOLD_CYCLES    = 500;
   localparam int DEF_TIMEOUT_CYCLES = 4096;

   typedef enum logic [2:0] {
      ST_HOLD     = 3'd0,
      ST_RELEASE  = 3'd1,
      ST_WAIT_RDY = 3'd2,
      ST_DONE     = 3'd3
`ifdef RSTSEQ_TIMEOUT_EN
      , ST_ERROR  = 3'd4
`endif
   } state_t;

   // Width that holds the larger of the two cycle budgets without wrapping.
   function automatic int cnt_width(input int hold_cycles, input int timeout_cycles);
      int max_v;
      max_v = (hold_cycles > timeout_cycles) ? hold_cycles : timeout_cycles;
      return (max_v < 1) ? 1 : $clog2(max_v + 1);
   endfunction

endpackage

// File: rtl/seq_counter.sv
// Cycle counter shared by the hold and ready-timeout phases.
// Clear has priority over enable; the count saturates rather than wrapping.
module seq_counter #(
   parameter int W = 13
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_clear,
   input  logic         i_enable,
   input  logic [W-1:0] i_terminal,
   output logic         o_tc
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_tc = (r_count == i_terminal);

endmodule

// File: rtl/reset_sequencer.sv
// Releases N_STAGES reset domains in order after a fixed hold, waiting for each
// stage's ready. Define RSTSEQ_TIMEOUT_EN to add the per-stage timeout / ERROR state.
module reset_sequencer
   import rstseq_pkg::*;
#(
   parameter int N_STAGES       = DEF_N_STAGES,
   parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   localparam int SW            = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                soft_req,
   input  logic [N_STAGES-1:0] stage_ready,
   output logic [N_STAGES-1:0] stage_reset,
   output logic [SW-1:0]       cur_stage,
   output logic                all_done,
   output logic                timeout_err,
   output state_t              dbg_state
);

   localparam int            CW   = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);
   localparam logic [SW-1:0] LAST = SW'(N_STAGES - 1);

   state_t              r_state, w_next;
   logic [SW-1:0]       r_cur_stage, w_cur_next;
   logic [N_STAGES-1:0] r_stage_reset, w_stage_reset_next;
   logic                w_cnt_clr, w_cnt_en, w_cnt_tc, w_ready;
   logic [CW-1:0]       w_cnt_term;

   seq_counter #(.W(CW)) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (w_cnt_clr),
      .i_enable   (w_cnt_en),
      .i_terminal (w_cnt_term),
      .o_tc       (w_cnt_tc)
   );

   // A stage still held in reset can never acknowledge.
   assign w_ready = stage_ready[r_cur_stage] & ~r_stage_reset[r_cur_stage];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_HOLD;
         r_cur_stage   <= '0;
         r_stage_reset <= '1;
      end else begin
         r_state       <= w_next;
         r_cur_stage   <= w_cur_next;
         r_stage_reset <= w_stage_reset_next;
      end
   end

   always_comb begin
      w_next             = r_state;
      w_cur_next         = r_cur_stage;
      w_stage_reset_next = r_stage_reset;
      w_cnt_clr          = 1'b0;
      w_cnt_en           = 1'b0;
      w_cnt_term         = CW'(HOLD_CYCLES - 1);
      if (soft_req) begin
         // Restart from any state, including a hold already in progress.
         w_next             = ST_HOLD;
         w_cur_next         = '0;
         w_stage_reset_next = '1;
         w_cnt_clr          = 1'b1;
      end else begin
         case (r_state)
            ST_HOLD: begin
               w_stage_reset_next = '1;
               if (w_cnt_tc) begin
                  w_next     = ST_RELEASE;
                  w_cur_next = '0;
                  w_cnt_clr  = 1'b1;
               end else begin
                  w_cnt_en = 1'b1;
               end
            end
            ST_RELEASE: begin
               w_stage_reset_next[r_cur_stage] = 1'b0;
               w_cnt_clr                       = 1'b1;
               w_next                          = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
`ifdef RSTSEQ_TIMEOUT_EN
               w_cnt_term = CW'(TIMEOUT_CYCLES - 1);
`endif
               if (w_ready) begin
                  w_cnt_clr = 1'b1;
                  if (r_cur_stage == LAST) begin
                     w_next = ST_DONE;
                  end else begin
                     w_cur_next = r_cur_stage + 1'b1;
                     w_next     = ST_RELEASE;
                  end
               end
`ifdef RSTSEQ_TIMEOUT_EN
               else if (w_cnt_tc) begin
                  w_next = ST_ERROR;
               end
`endif
               else begin
                  w_cnt_en = 1'b1;
               end
            end
            ST_DONE: begin
               w_stage_reset_next = '0;
            end
`ifdef RSTSEQ_TIMEOUT_EN
            // Frozen with the failed stage released until soft_req or reset.
            ST_ERROR: begin
               w_next = ST_ERROR;
            end
`endif
            default: begin
               w_next             = ST_HOLD;
               w_cur_next         = '0;
               w_stage_reset_next = '1;
               w_cnt_clr          = 1'b1;
            end
         endcase
      end
   end

   assign stage_reset = r_stage_reset;
   assign cur_stage   = r_cur_stage;
   assign all_done    = (r_state == ST_DONE);
   assign dbg_state   = r_state;
`ifdef RSTSEQ_TIMEOUT_EN
   assign timeout_err = (r_state == ST_ERROR);
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: an event-level reference model predicts every output change
// (cycle + value) into a queue; a negedge monitor pops and compares on each DUT change.
module tb_reset_sequencer;
   import rstseq_pkg::*;

   localparam int HOLD = 500;
   localparam int TMO  = 4096;
   localparam int BIG  = 1 << 30;
   localparam int STUCK = 1000000;
   localparam int EW   = 40;
   localparam logic [7:0] RST_TUP = 8'b0000_1111;

   logic       clk = 1'b0;
   logic       reset;
   logic       soft_req;
   logic [3:0] stage_ready;
   logic [3:0] stage_reset;
   logic [1:0] cur_stage;
   logic       all_done, timeout_err;
   state_t     dbg_state;

   int cyc = 0;
   int n_assert = 0;
   int n_fail = 0;

   // Expected events: {cycle[31:0], {all_done, timeout_err, cur_stage, stage_reset}}
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] hist[$];
   logic [7:0]    model_last = RST_TUP;
   logic [7:0]    mon_last   = RST_TUP;

   int dly[4], hext[4], rdy_on[4], rdy_off[4], rel_t[4], acc_t[4];

   reset_sequencer #(.N_STAGES(4), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
      .clk         (clk),
      .reset       (reset),
      .soft_req    (soft_req),
      .stage_ready (stage_ready),
      .stage_reset (stage_reset),
      .cur_stage   (cur_stage),
      .all_done    (all_done),
      .timeout_err (timeout_err),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #600000;
      n_fail++;
      $display("FAIL watchdog: simulation ran past its cycle budget (cyc %0d)", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $fatal(1, "watchdog");
   end

   // ---------------- model helpers ----------------
   function automatic logic [7:0] tup(input logic [3:0] sr, input int cur,
                                      input logic done, input logic err);
      return {done, err, 2'(cur), sr};
   endfunction

   function automatic int ev_cyc(input logic [EW-1:0] e);
      return int'(e[39:8]);
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      n_assert++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual 'h%0h required 'h%0h (cyc %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_ev(input int c, input logic [7:0] t);
      if (t != model_last) begin
         exp_q.push_back({32'(c), t});
         hist.push_back({32'(c), t});
         model_last = t;
      end
   endtask

   task automatic flush_from(input int c);
      while (exp_q.size() > 0 && ev_cyc(exp_q[exp_q.size()-1]) >= c) void'(exp_q.pop_back());
      while (hist.size() > 0 && ev_cyc(hist[hist.size()-1]) >= c) void'(hist.pop_back());
      model_last = (hist.size() > 0) ? hist[hist.size()-1][7:0] : RST_TUP;
   endtask

   // Hold begins evaluating at edge r; stage i is released 1 cycle after the hold,
   // accepted k edges later (ready first seen), next release the cycle after that.
   task automatic plan_seq(input int r);
      int t, k;
      logic [3:0] sr;
      sr = 4'b1111;
      t  = r + HOLD;
      for (int i = 0; i < 4; i++) begin
         rdy_on[i] = BIG; rdy_off[i] = BIG; rel_t[i] = BIG; acc_t[i] = BIG;
      end
      for (int i = 0; i < 4; i++) begin
         sr[i]     = 1'b0;
         rel_t[i]  = t;
         push_ev(t, tup(sr, i, 1'b0, 1'b0));
         rdy_on[i] = t + dly[i];
         k = (dly[i] > 0) ? dly[i] + 1 : 1;
`ifdef RSTSEQ_TIMEOUT_EN
         if (k > TMO) begin
            push_ev(t + TMO, tup(sr, i, 1'b0, 1'b1));
            return;
         end
`endif
         acc_t[i]   = t + k;
         rdy_off[i] = t + k + hext[i];
         if (i == 3) push_ev(t + k, tup(sr, 3, 1'b1, 1'b0));
         else        push_ev(t + k, tup(sr, i + 1, 1'b0, 1'b0));
         t = t + k + 1;
      end
   endtask

   function automatic int last_ev_cyc();
      return ev_cyc(hist[hist.size()-1]);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic set_dly(input int lo, input int hi);
      for (int i = 0; i < 4; i++) begin
         dly[i]  = int'($urandom_range(hi - lo)) + lo;
         hext[i] = int'($urandom_range(4));
      end
   endtask

   task automatic do_soft();
      int s;
      s = cyc + 1;
      soft_req = 1'b1;
      flush_from(s);
      push_ev(s, RST_TUP);
      tick();
      soft_req = 1'b0;
   endtask

   task automatic wait_seq_done();
      wait_until(last_ev_cyc() + 3);
      check("queue_drained", exp_q.size(), 0);
   endtask

   always @(negedge clk) begin
      #2;
      for (int i = 0; i < 4; i++) stage_ready[i] = (cyc >= rdy_on[i]) && (cyc < rdy_off[i]);
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [7:0]    now_t;
      logic [EW-1:0] e;
      now_t = {all_done, timeout_err, cur_stage, stage_reset};
      if (now_t !== mon_last) begin
         if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL unexpected_change: actual 'h%0h required 'h%0h (cyc %0d)", now_t, mon_last, cyc);
         end else begin
            e = exp_q.pop_front();
            check("event_outputs", now_t, e[7:0]);
            check("event_cycle", cyc, ev_cyc(e));
         end
         mon_last = now_t;
      end else if (exp_q.size() > 0 && ev_cyc(exp_q[0]) < cyc) begin
         e = exp_q.pop_front();
         n_assert++;
         n_fail++;
         $display("FAIL event_missed: actual 'h%0h required 'h%0h at cyc %0d (now %0d)", now_t, e[7:0], ev_cyc(e), cyc);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1;
      soft_req = 1'b0;
      stage_ready = '0;
      for (int i = 0; i < 4; i++) begin
         dly[i] = 0; hext[i] = 0; rdy_on[i] = BIG; rdy_off[i] = BIG;
      end
      repeat (5) tick();
      check("rst_stage_reset", stage_reset, 4'b1111);
      check("rst_cur_stage", cur_stage, 0);
      check("rst_all_done", all_done, 0);
      check("rst_timeout_err", timeout_err, 0);

      // Power-up with every ready tied high.
      for (int i = 0; i < 4; i++) begin dly[i] = -1000; hext[i] = STUCK; end
      reset = 1'b0;
      plan_seq(cyc + 1);
      wait_seq_done();
      check("powerup_all_done", all_done, 1);

      // Stage 2 ready arrives 100 cycles after its release.
      set_dly(0, 10);
      dly[2] = 100;
      do_soft();
      plan_seq(cyc + 1);
      wait_seq_done();

      // Stage 3 ready raised during the hold must be ignored.
      set_dly(0, 8);
      dly[3] = -(HOLD + 20);
      do_soft();
      plan_seq(cyc + 1);
      wait_seq_done();

      // soft_req 50 cycles into the wait on stage 1.
      set_dly(0, 5);
      dly[1] = STUCK;
      do_soft();
      plan_seq(cyc + 1);
      wait_until(rel_t[1] + 49);
      set_dly(-5, 20);
      do_soft();
      plan_seq(cyc + 1);
      wait_seq_done();

      // Randomised sequences.
      for (int n = 0; n < 3; n++) begin
         set_dly(-5, 30);
         do_soft();
         plan_seq(cyc + 1);
         wait_seq_done();
      end

      // soft_req in the same cycle stage 2's ready is sampled.
      set_dly(0, 6);
      do_soft();
      plan_seq(cyc + 1);
      wait_until(acc_t[2] - 1);
      set_dly(0, 6);
      do_soft();
      plan_seq(cyc + 1);
      wait_seq_done();

      // soft_req in the middle of a hold restarts the full hold.
      set_dly(0, 4);
      do_soft();
      plan_seq(cyc + 1);
      wait_until(cyc + 200);
      do_soft();
      plan_seq(cyc + 1);
      wait_seq_done();

      // Asynchronous reset mid-cycle during the release of stage 2.
      set_dly(0, 6);
      do_soft();
      plan_seq(cyc + 1);
      wait_until(acc_t[1] - 1);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("async_stage_reset", stage_reset, 4'b1111);
      check("async_cur_stage", cur_stage, 0);
      check("async_all_done", all_done, 0);
      check("async_timeout_err", timeout_err, 0);
      flush_from(acc_t[1]);
      push_ev(acc_t[1], RST_TUP);
      repeat (3) tick();
      set_dly(0, 6);
      reset = 1'b0;
      plan_seq(cyc + 1);
      wait_seq_done();

      // Stage 1 never becomes ready.
      set_dly(0, 4);
      dly[1] = STUCK;
      do_soft();
      plan_seq(cyc + 1);
`ifdef RSTSEQ_TIMEOUT_EN
      wait_seq_done();
      check("tmo_err", timeout_err, 1);
      check("tmo_stage_reset", stage_reset, 4'b1100);
      check("tmo_cur_stage", cur_stage, 1);
`else
      wait_until(rel_t[1] + 10000);
      check("notmo_err", timeout_err, 0);
      check("notmo_stage_reset", stage_reset, 4'b1100);
      check("notmo_cur_stage", cur_stage, 1);
`endif
      set_dly(0, 6);
      do_soft();
      check("soft_clears_err", timeout_err, 0);
      plan_seq(cyc + 1);
      wait_seq_done();

      check("final_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter N_STAGES, default 4: number of downstream reset domains, released in index order 0..N_STAGES-1.
REQ-002 SHALL have parameter HOLD_CYCLES, default 500: clk cycles all stage resets are held asserted (20us at 25MHz).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum clk cycles to wait for one stage's ready.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, the 25MHz internal clock.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port soft_req, input, 1 bit: single-cycle pulse requesting a full re-sequence.
REQ-007 SHALL have port stage_ready, input, N_STAGES bits: per-stage "initialised" acknowledge.
REQ-008 SHALL have port stage_reset, output, N_STAGES bits: per-stage active-high reset.
REQ-009 SHALL have port cur_stage, output, clog2(N_STAGES) bits: index of the stage being released or awaited.
REQ-010 SHALL have port all_done, output, 1 bit: high while every stage is released and acknowledged.
REQ-011 SHALL have port timeout_err, output, 1 bit: high while in ERROR.

Function
REQ-012 SHALL implement the FSM states HOLD, RELEASE, WAIT_RDY, DONE and ERROR.
REQ-013 In HOLD: stage_reset all ones; counter increments; after exactly HOLD_CYCLES cycles in HOLD, go to RELEASE with cur_stage=0.
REQ-014 RELEASE (1 cycle): clear stage_reset[cur_stage]; clear counter; go to WAIT_RDY.
REQ-015 In WAIT_RDY: stage_ready[cur_stage] sampled high -> cur_stage+1 and RELEASE, or DONE if cur_stage==N_STAGES-1; otherwise counter increments.
REQ-016 stage_ready of a stage still held in reset SHALL be ignored.
REQ-017 Released stages SHALL stay released until HOLD is re-entered; ready deassertion after acceptance is ignored.
REQ-018 DONE: all_done=1, stage_reset all zero; remain until soft_req.
REQ-019 soft_req sampled high in any state other than HOLD SHALL go to HOLD next cycle: stage_reset all ones, counter=0, cur_stage=0, all_done=0, timeout_err=0.
REQ-020 soft_req during HOLD SHALL restart the hold count from 0.
REQ-021 soft_req and stage_ready high in the same cycle: soft_req SHALL win.
REQ-022 Counter SHALL be wide enough for max(HOLD_CYCLES, TIMEOUT_CYCLES) and SHALL never wrap in operation.

Reset
REQ-023 reset asserted SHALL immediately (asynchronously) force HOLD, stage_reset all ones, counter 0, cur_stage 0, all_done 0, timeout_err 0.
REQ-024 reset asserted mid-sequence SHALL abort that sequence; a fresh full hold SHALL follow reset deassertion.

Configuration
REQ-025 With macro RSTSEQ_TIMEOUT_EN defined: WAIT_RDY exceeding TIMEOUT_CYCLES without ready -> ERROR; in ERROR, timeout_err=1, cur_stage frozen, stage_reset frozen (failed stage released, later stages held); exit only via soft_req or reset.
REQ-026 Without RSTSEQ_TIMEOUT_EN: no ERROR state and no timeout logic; WAIT_RDY waits indefinitely; timeout_err tied 0.

Structure
REQ-027 Package rstseq_pkg SHALL hold the FSM state enum, the default parameter constants and the counter-width function.
REQ-028 One sub-module, seq_counter (clear, enable, terminal-count compare), SHALL be shared by the hold and timeout counting.

Verification
REQ-029 Power-up: reset 5 cycles, all stage_ready tied high -> stage_reset=4'b1111 for 500 cycles, then bits clear one by one 2 cycles apart, all_done=1.
REQ-030 Ready delay: stage_ready[2] asserted 100 cycles after its release -> stage_reset[3] clears exactly 2 cycles after stage_ready[2] is sampled; cur_stage=2 throughout the wait.
REQ-031 Early ready: stage_ready=4'b1000 during HOLD -> ignored; stage 3 still released last.
REQ-032 soft_req in DONE, and again 50 cycles into WAIT_RDY of stage 1 -> stage_reset=4'b1111 next cycle each time, then a full 500-cycle hold.
REQ-033 With RSTSEQ_TIMEOUT_EN defined, stage_ready[1] held 0 -> timeout_err=1 after 4096 wait cycles, stage_reset=4'b1100, cur_stage=1; soft_req clears the error. Without the macro: no error after 10000 cycles.
REQ-034 Async reset asserted mid-clock during RELEASE of stage 2 -> outputs reach reset values before the next clk edge.
